// File: rtl/conbus_wrr_arb.sv
// Weighted round-robin grant generator for the shared Wishbone interconnect.
// Optional bus watchdog is compiled in with `define CONBUS_WDT_EN.

module conbus_wrr_wreg #(
  parameter int W_W        = 4,
  parameter int DEF_WEIGHT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           we,
  input  logic [W_W-1:0] wdata,
  output logic [W_W-1:0] eff_w
);
  logic [W_W-1:0] w;

  always_ff @(posedge clk) begin
    if (rst)     w <= W_W'(DEF_WEIGHT);
    else if (we) w <= wdata;
  end

  // A programmed weight of zero still grants one burst per turn.
  assign eff_w = (w == '0) ? W_W'(1) : w;
endmodule

module conbus_wrr_arb #(
  parameter int N_MST      = 7,
  parameter int IDX_W      = 3,
  parameter int W_W        = 4,
  parameter int DEF_WEIGHT = 1,
  parameter int TIMEOUT    = 255
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [N_MST-1:0] req,
  input  logic             bus_stb,
  input  logic             bus_ack,
  input  logic [2:0]       bus_cti,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [W_W-1:0]   cfg_weight,
  output logic [N_MST-1:0] gnt,
  output logic [IDX_W-1:0] owner,
  output logic [W_W-1:0]   quota_left,
  output logic             wdt_err
);
  localparam logic [W_W-1:0] RST_QUOTA = (DEF_WEIGHT == 0) ? W_W'(1) : W_W'(DEF_WEIGHT);

  typedef enum logic {PARK, OWN} state_t;
  state_t state;

  if (N_MST < 2 || N_MST > 8 || (1 << IDX_W) < N_MST || TIMEOUT < 1) begin : g_param_chk
    $error("conbus_wrr_arb: illegal parameter set");
  end

  logic [N_MST-1:0][W_W-1:0] eff_w;

  for (genvar gi = 0; gi < N_MST; gi++) begin : g_mst
    conbus_wrr_wreg #(.W_W(W_W), .DEF_WEIGHT(DEF_WEIGHT)) u_wreg (
      .clk  (sys_clk),
      .rst  (sys_rst),
      .we   (cfg_we && (cfg_idx == IDX_W'(gi))),
      .wdata(cfg_weight),
      .eff_w(eff_w[gi])
    );
  end

  logic             burst_end;
  logic             own_req;
  logic             oth_vld;
  logic [IDX_W-1:0] oth_idx;
  logic             wdt_fire;
  logic             quota_exh;
  logic             handoff;

  assign burst_end = bus_stb && bus_ack && (bus_cti == 3'b000 || bus_cti == 3'b111);
  assign own_req   = req[owner];

  // Nearest requester after the owner; descending scan so the smallest
  // distance is the last (winning) assignment.
  always_comb begin
    logic [IDX_W-1:0] m;
    oth_vld = 1'b0;
    oth_idx = owner;
    m       = '0;
    for (int k = N_MST-1; k >= 1; k--) begin
      m = IDX_W'((int'(owner) + k) % N_MST);
      if (req[m]) begin
        oth_vld = 1'b1;
        oth_idx = m;
      end
    end
  end

  assign quota_exh = (quota_left <= W_W'(1)) || wdt_fire;

  // Owner drop outranks a coincident burst end, so no decrement is seen.
  always_comb begin
    handoff = 1'b0;
    if (state == PARK) handoff = oth_vld;
    else               handoff = oth_vld && (!own_req || ((burst_end || wdt_fire) && quota_exh));
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= PARK;
      owner      <= '0;
      gnt        <= N_MST'(1);
      quota_left <= RST_QUOTA;
    end else if (handoff) begin
      state      <= OWN;
      owner      <= oth_idx;
      gnt        <= N_MST'(1) << oth_idx;
      quota_left <= eff_w[oth_idx];
    end else begin
      case (state)
        PARK: if (own_req) begin
          state      <= OWN;
          quota_left <= eff_w[owner];
        end
        OWN: begin
          if (!own_req)
            state <= PARK;
          else if (burst_end || wdt_fire)
            quota_left <= quota_exh ? eff_w[owner] : quota_left - W_W'(1);
        end
        default: state <= PARK;
      endcase
    end
  end

`ifdef CONBUS_WDT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wdt_cnt;

  assign wdt_fire = (state == OWN) && (wdt_cnt == CW'(TIMEOUT));
  assign wdt_err  = wdt_fire;

  always_ff @(posedge sys_clk) begin
    if (sys_rst || wdt_fire || handoff || state != OWN || !bus_stb || bus_ack)
      wdt_cnt <= '0;
    else
      wdt_cnt <= wdt_cnt + CW'(1);
  end
`else
  assign wdt_fire = 1'b0;
  assign wdt_err  = 1'b0;
`endif
endmodule

// File: tb/tb_conbus_wrr_arb.sv
// Directed bench for conbus_wrr_arb, default build (watchdog disabled).
module tb_conbus_wrr_arb;
  localparam int N_MST = 7, IDX_W = 3, W_W = 4;

  logic             sys_clk = 1'b0;
  logic             sys_rst;
  logic [N_MST-1:0] req;
  logic             bus_stb, bus_ack;
  logic [2:0]       bus_cti;
  logic             cfg_we;
  logic [IDX_W-1:0] cfg_idx;
  logic [W_W-1:0]   cfg_weight;
  logic [N_MST-1:0] gnt;
  logic [IDX_W-1:0] owner;
  logic [W_W-1:0]   quota_left;
  logic             wdt_err;

  int n_chk  = 0;
  int n_fail = 0;

  conbus_wrr_arb #(.N_MST(N_MST), .IDX_W(IDX_W), .W_W(W_W), .DEF_WEIGHT(1), .TIMEOUT(255)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .req       (req),
    .bus_stb   (bus_stb),
    .bus_ack   (bus_ack),
    .bus_cti   (bus_cti),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_weight(cfg_weight),
    .gnt       (gnt),
    .owner     (owner),
    .quota_left(quota_left),
    .wdt_err   (wdt_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic st(input string tag, input logic [31:0] g, input logic [31:0] o, input logic [31:0] q);
    chk({tag, ".gnt"}, gnt, g);
    chk({tag, ".owner"}, owner, o);
    chk({tag, ".quota"}, quota_left, q);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic bus(input logic s, input logic a, input logic [2:0] c);
    bus_stb = s; bus_ack = a; bus_cti = c;
  endtask

  task automatic cfg(input logic we, input logic [IDX_W-1:0] idx, input logic [W_W-1:0] w);
    cfg_we = we; cfg_idx = idx; cfg_weight = w;
  endtask

  initial begin
    sys_rst = 1'b1; req = 7'h7F;
    bus(1'b0, 1'b0, 3'b000);
    cfg(1'b0, 3'd0, 4'd0);
    tick(); tick();
    st("reset", 32'h01, 0, 1);
    chk("reset.wdt_err", wdt_err, 0);

    sys_rst = 1'b0; req = 7'h00;
    tick(); st("park_idle", 32'h01, 0, 1);

    // plain round-robin, masters 0 and 3 with single transfers
    req = 7'h09;
    tick(); st("rr_first", 32'h08, 3, 1);
    bus(1'b1, 1'b1, 3'b000);
    tick(); st("rr_to0", 32'h01, 0, 1);
    tick(); st("rr_to3", 32'h08, 3, 1);
    tick(); st("rr_to0b", 32'h01, 0, 1);
    bus(1'b0, 1'b0, 3'b000); req = 7'h00;
    tick(); st("rr_park", 32'h01, 0, 1);

    // weighting: weight[2]=3, weight[5]=1
    cfg(1'b1, 3'd2, 4'd3); tick();
    cfg(1'b1, 3'd5, 4'd1); tick();
    cfg(1'b0, 3'd0, 4'd0);
    st("cfg_park", 32'h01, 0, 1);
    req = 7'h24;
    tick(); st("wt_m2_q3", 32'h04, 2, 3);
    bus(1'b1, 1'b1, 3'b000);
    tick(); st("wt_q2", 32'h04, 2, 2);
    tick(); st("wt_q1", 32'h04, 2, 1);
    tick(); st("wt_m5", 32'h20, 5, 1);
    tick(); st("wt_m2_again", 32'h04, 2, 3);
    bus(1'b0, 1'b0, 3'b000); req = 7'h00;
    tick(); st("wt_park", 32'h04, 2, 3);

    // burst boundary: master 1 incrementing burst, master 4 waiting
    req = 7'h02;
    tick(); st("bb_m1", 32'h02, 1, 1);
    req = 7'h12;
    bus(1'b1, 1'b0, 3'b010);
    tick(); st("bb_wait", 32'h02, 1, 1);
    bus(1'b1, 1'b1, 3'b010);
    tick(); st("bb_beat1", 32'h02, 1, 1);
    tick(); st("bb_beat2", 32'h02, 1, 1);
    tick(); st("bb_beat3", 32'h02, 1, 1);
    bus(1'b1, 1'b1, 3'b111);
    tick(); st("bb_end", 32'h10, 4, 1);
    bus(1'b0, 1'b0, 3'b000); req = 7'h00;
    tick(); st("bb_park", 32'h10, 4, 1);

    // out-of-range config index must not alias onto a real master
    cfg(1'b1, 3'd7, 4'd5); tick();
    cfg(1'b0, 3'd0, 4'd0);
    req = 7'h01;
    tick(); st("cfg7_ign", 32'h01, 0, 1);

    // weight[0]=0 behaves as 1
    cfg(1'b1, 3'd0, 4'd0);
    tick(); st("w0_write", 32'h01, 0, 1);
    cfg(1'b0, 3'd0, 4'd0);
    req = 7'h09; bus(1'b1, 1'b1, 3'b000);
    tick(); st("w0_to3", 32'h08, 3, 1);
    tick(); st("w0_turn", 32'h01, 0, 1);
    tick(); st("w0_next", 32'h08, 3, 1);
    bus(1'b0, 1'b0, 3'b000); req = 7'h00;
    tick(); st("w0_park", 32'h08, 3, 1);

    // write to the owner mid-turn leaves the running quota alone
    req = 7'h04;
    tick(); st("mid_m2", 32'h04, 2, 3);
    bus(1'b1, 1'b1, 3'b000);
    tick(); st("mid_q2", 32'h04, 2, 2);
    bus(1'b0, 1'b0, 3'b000); cfg(1'b1, 3'd2, 4'd1);
    tick(); st("mid_wr_keep", 32'h04, 2, 2);
    cfg(1'b0, 3'd0, 4'd0); bus(1'b1, 1'b1, 3'b000);
    tick(); st("mid_q1", 32'h04, 2, 1);
    tick(); st("mid_reload_new", 32'h04, 2, 1);

    // write and reload in the same cycle: reload sees the old weight
    cfg(1'b1, 3'd2, 4'd4);
    tick(); st("same_cyc_old", 32'h04, 2, 1);
    cfg(1'b0, 3'd0, 4'd0);
    tick(); st("same_cyc_new", 32'h04, 2, 4);
    tick(); st("dec_q3", 32'h04, 2, 3);

    // owner drops req on the burst-end cycle: handoff, no decrement
    req = 7'h01;
    tick(); st("drop_at_end", 32'h01, 0, 1);
    bus(1'b0, 1'b0, 3'b000); req = 7'h40;
    tick(); st("drop_handoff", 32'h40, 6, 1);

    // reset mid-operation, weights back to default
    sys_rst = 1'b1;
    tick(); st("rst_mid", 32'h01, 0, 1);
    sys_rst = 1'b0; req = 7'h04;
    tick(); st("rst_weights", 32'h04, 2, 1);
    chk("end.wdt_err", wdt_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
